// File: rtl/h264_chroma_dc_pkg.sv
// h264_chroma_dc_pkg: shared widths and types for the chroma DC Hadamard stage
package h264_chroma_dc_pkg;
  localparam int dc_width = 16;
  localparam int coef_width = dc_width + 2;
  typedef logic signed [coef_width-1:0] coef_t;
  typedef enum logic [1:0] {empty, filling, full, draining} bank_st_t;
  typedef enum logic {cb, cr} comp_t;
endpackage

// File: rtl/hadamard2x2_comb.sv
// hadamard2x2_comb: combinational 2x2 Hadamard butterfly on sign-extended DC sums
module hadamard2x2_comb
  import h264_chroma_dc_pkg::*;
#(
  parameter int DCW = dc_width,
  parameter int CW = coef_width
) (
  input  logic signed [DCW-1:0] a,
  input  logic signed [DCW-1:0] b,
  input  logic signed [DCW-1:0] c,
  input  logic signed [DCW-1:0] d,
  output logic signed [CW-1:0]  f0,
  output logic signed [CW-1:0]  f1,
  output logic signed [CW-1:0]  f2,
  output logic signed [CW-1:0]  f3
);
  logic signed [CW-1:0] ea, eb, ec, ed, s0, d0, s1, d1;
  assign ea = CW'(a);
  assign eb = CW'(b);
  assign ec = CW'(c);
  assign ed = CW'(d);
  assign s0 = ea + eb;
  assign d0 = ea - eb;
  assign s1 = ec + ed;
  assign d1 = ec - ed;
  assign f0 = s0 + s1;
  assign f1 = d0 + d1;
  assign f2 = s0 - s1;
  assign f3 = d0 - d1;
endmodule

// File: rtl/chroma_dc_hadamard2x2_stage.sv
// chroma_dc_hadamard2x2_stage: collects 4 chroma DC sums per component, applies the
// 2x2 Hadamard and streams coefficients from two ping-pong banks under valid/ready.
module chroma_dc_hadamard2x2_stage
  import h264_chroma_dc_pkg::*;
#(
  parameter int DCW = dc_width,
  parameter int CW = coef_width
) (
  input  logic           CLK2,
  input  logic           RESET,
  input  logic           NEWSLICE,
  input  logic           DCSTROBEI,
  input  logic [DCW-1:0] DCDATAI,
  output logic           READYO,
  output logic           STROBEO,
  input  logic           READYI,
  output logic [CW-1:0]  DATAO,
  output logic           CBCRO,
  output logic [1:0]     IDXO,
  output logic           LASTO,
  output logic           OVERFLOW
);
  logic signed [DCW-1:0] s [4];
  logic signed [CW-1:0] f [4];
  logic signed [CW-1:0] cf [2][4];
  bank_st_t st [2];
  comp_t tg [2];
  comp_t tag, ptag;
  logic [1:0] cnt;
  logic fp, rp, pb, pend, take, fin, nb;
  hadamard2x2_comb #(.DCW(DCW), .CW(CW)) u_had (
    .a(s[0]), .b(s[1]), .c(s[2]), .d(s[3]),
    .f0(f[0]), .f1(f[1]), .f2(f[2]), .f3(f[3])
  );
  assign READYO = st[fp] == empty || st[fp] == filling;
  // a component that lost its first sample is dropped whole, keeping slots aligned
  assign take = DCSTROBEI && READYO && (cnt == 2'd0 || st[fp] == filling);
  assign fin = STROBEO && READYI && IDXO == 2'd3;
  assign nb = fin ? ~rp : rp;
  always_ff @(posedge CLK2) begin
    if (RESET || NEWSLICE) begin
      st[0] <= (!RESET && DCSTROBEI) ? filling : empty;
      st[1] <= empty;
      s[0] <= DCDATAI;
      cnt <= {1'b0, !RESET && DCSTROBEI};
      fp <= 1'b0;
      rp <= 1'b0;
      pend <= 1'b0;
      tag <= cb;
      STROBEO <= 1'b0;
      DATAO <= '0;
      CBCRO <= 1'b0;
      IDXO <= '0;
      LASTO <= 1'b0;
      OVERFLOW <= OVERFLOW && !RESET;
    end else begin
      // the bank completed last cycle gets its coefficients now
      if (pend) begin
        st[pb] <= full;
        tg[pb] <= ptag;
        for (int i = 0; i < 4; i++) cf[pb][i] <= f[i];
      end
      pend <= take && cnt == 2'd3;
      if (DCSTROBEI) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) tag <= tag == cb ? cr : cb;
      end
      if (take) begin
        s[cnt] <= DCDATAI;
        st[fp] <= filling;
        if (cnt == 2'd3) begin
          fp <= ~fp;
          pb <= fp;
          ptag <= tag;
        end
      end
      if (DCSTROBEI && !take) OVERFLOW <= 1'b1;
      if (fin) begin
        st[rp] <= empty;
        rp <= ~rp;
      end
      if (!STROBEO || fin) begin
        STROBEO <= st[nb] == full;
        if (st[nb] == full) begin
          st[nb] <= draining;
          DATAO <= cf[nb][0];
          CBCRO <= tg[nb];
          IDXO <= '0;
          LASTO <= 1'b0;
        end
      end else if (READYI) begin
        DATAO <= cf[rp][IDXO + 2'd1];
        IDXO <= IDXO + 2'd1;
        LASTO <= IDXO == 2'd2;
      end
    end
  end
  assert property (@(posedge CLK2) STROBEO && !READYI && !RESET && !NEWSLICE |=> $stable(DATAO));
  assert property (@(posedge CLK2) STROBEO && READYI && !RESET && !NEWSLICE |=> !STROBEO || IDXO == $past(IDXO) + 2'd1);
endmodule
